// File: rtl/queue_dispatcher_if.sv
// Dispatcher-side bundle: arbiter handshake, FWFT queue heads/pops and downstream transaction port.
interface queue_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 32
);
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

  logic                                        valid;
  logic [SEL_W-1:0]                            selection;
  logic                                        update;
  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] q_data;
  logic [NUMBER_OF_QUEUES-1:0]                 q_empty;
  logic [NUMBER_OF_QUEUES-1:0]                 q_pop;
  logic                                        m_valid;
  logic                                        m_ready;
  logic [DATA_WIDTH-1:0]                       m_data;
  logic [SEL_W-1:0]                            m_source;

  modport master (
    input  valid, selection, q_data, q_empty, m_ready,
    output q_pop, m_valid, m_data, m_source, update
  );

  modport slave (
    output valid, selection, q_data, q_empty, m_ready,
    input  q_pop, m_valid, m_data, m_source, update
  );
endinterface

// File: rtl/queue_dispatcher.sv
// Moves one word from the arbiter-selected queue to the downstream port per transaction,
// signalling completion to the arbiter and keeping saturating per-queue served counts.
module queue_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                                         clock,
  input  logic                                         reset,
  queue_dispatcher_if.master                           bus,
  input  logic                                         clear_counts,
  output logic [NUMBER_OF_QUEUES-1:0][COUNT_WIDTH-1:0] served_count
);
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t                state, state_d;
  logic [SEL_W-1:0]      sel_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  accept, handshake;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Arbiter inputs are only looked at in IDLE, so a transaction can never be re-targeted.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: if (bus.valid && !bus.q_empty[bus.selection]) begin
        accept  = 1'b1;
        state_d = SEND;
      end
      SEND: if (bus.m_ready) begin
        handshake = 1'b1;
        state_d   = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The word is captured at accept, so the pop can retire the head while SEND is still held.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_r       <= '0;
      data_r      <= '0;
      bus.q_pop   <= '0;
      bus.m_valid <= 1'b0;
      bus.update  <= 1'b0;
    end else begin
      bus.q_pop <= '0;
      if (accept) begin
        sel_r                     <= bus.selection;
        data_r                    <= bus.q_data[bus.selection];
        bus.q_pop[bus.selection]  <= 1'b1;
        bus.m_valid               <= 1'b1;
        bus.update                <= 1'b1;
      end else if (handshake) begin
        bus.m_valid <= 1'b0;
        bus.update  <= 1'b0;
      end
    end
  end

  assign bus.m_data   = data_r;
  assign bus.m_source = sel_r;

  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      served_count <= '0;
    end else if (handshake) begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++)
        if (sel_r == SEL_W'(i) && served_count[i] != '1)
          served_count[i] <= served_count[i] + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench: stimulus pushes expected transactions, a negedge monitor pops and compares.
module tb_queue_dispatcher;
  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    src;
  } txn_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   clear_counts;
  logic [NQ-1:0][CW-1:0]  served_count;

  always #5 clock = ~clock;

  queue_dispatcher_if #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW)) bus ();

  queue_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .clear_counts (clear_counts),
    .served_count (served_count)
  );

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  int   pop_cnt[NQ] = '{default: 0};
  int   pop_total = 0, upd_cycles = 0, fall_cnt = 0, mv_cycles = 0, hs_cnt = 0;
  logic prev_upd = 1'b0, prev_mv = 1'b0, prev_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [1:0]    prev_src = '0;

  int s_pop[NQ];
  int s_total, s_upd, s_fall, s_mv, s_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle invariants, event counters and the scoreboard pop.
  always @(negedge clock) begin
    txn_t t;
    logic hs;
    chk("pop_onehot", 64'($countones(bus.q_pop) <= 1), 64'd1);
    chk("update_eq_mvalid", 64'(bus.update), 64'(bus.m_valid));
    for (int i = 0; i < NQ; i++) if (bus.q_pop[i]) pop_cnt[i]++;
    pop_total += $countones(bus.q_pop);
    if (bus.update) upd_cycles++;
    if (prev_upd && !bus.update) fall_cnt++;
    if (bus.m_valid) mv_cycles++;
    if (prev_mv && !prev_hs && bus.m_valid)
      chk("m_stable", {30'd0, bus.m_source, bus.m_data}, {30'd0, prev_src, prev_data});
    hs = bus.m_valid && bus.m_ready;
    if (hs) begin
      hs_cnt++;
      chk("txn_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk("m_data", 64'(bus.m_data), 64'(t.data));
        chk("m_source", 64'(bus.m_source), 64'(t.src));
      end
    end
    prev_upd  = bus.update;
    prev_mv   = bus.m_valid;
    prev_hs   = hs;
    prev_data = bus.m_data;
    prev_src  = bus.m_source;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < NQ; i++) s_pop[i] = pop_cnt[i];
    s_total = pop_total; s_upd = upd_cycles; s_fall = fall_cnt; s_mv = mv_cycles; s_hs = hs_cnt;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clock);
      k++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    cyc(2);
  endtask

  initial begin
    logic [NQ-1:0][CW-1:0] e_cnt;
    reset = 1'b1; clear_counts = 1'b0;
    bus.valid = 1'b0; bus.selection = '0; bus.m_ready = 1'b0; bus.q_empty = '1;
    for (int i = 0; i < NQ; i++) bus.q_data[i] = 32'hCAFE0000 + i;
    cyc(2);
    chk("rst_q_pop", 64'(bus.q_pop), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_m_source", 64'(bus.m_source), 64'd0);
    chk("rst_update", 64'(bus.update), 64'd0);
    chk("rst_served", 64'(served_count), 64'd0);
    reset = 1'b0;
    cyc(1);

    // single transfer from queue 2
    snap();
    bus.q_empty = 4'b1011; bus.selection = 2; bus.m_ready = 1'b1;
    exp_q.push_back('{32'hCAFE0002, 2'd2});
    bus.valid = 1'b1; cyc(1); bus.valid = 1'b0;
    drain();
    chk("single_pop_q2", 64'(pop_cnt[2] - s_pop[2]), 64'd1);
    chk("single_pop_total", 64'(pop_total - s_total), 64'd1);
    chk("single_update_cycles", 64'(upd_cycles - s_upd), 64'd1);
    chk("single_update_falls", 64'(fall_cnt - s_fall), 64'd1);
    chk("single_served2", 64'(served_count[2]), 64'd1);

    // backpressure: five stalled SEND cycles then accept
    snap();
    bus.q_empty = 4'b0000; bus.selection = 1; bus.m_ready = 1'b0;
    exp_q.push_back('{32'hCAFE0001, 2'd1});
    bus.valid = 1'b1; cyc(1); bus.valid = 1'b0;
    cyc(5); bus.m_ready = 1'b1;
    drain();
    chk("bp_mvalid_cycles", 64'(mv_cycles - s_mv), 64'd6);
    chk("bp_update_cycles", 64'(upd_cycles - s_upd), 64'd6);
    chk("bp_pop_total", 64'(pop_total - s_total), 64'd1);
    chk("bp_pop_q1", 64'(pop_cnt[1] - s_pop[1]), 64'd1);
    chk("bp_update_falls", 64'(fall_cnt - s_fall), 64'd1);
    chk("bp_served1", 64'(served_count[1]), 64'd1);

    // empty guard
    snap();
    bus.q_empty = 4'b0010; bus.selection = 1;
    bus.valid = 1'b1; cyc(10); bus.valid = 1'b0;
    chk("empty_pop_total", 64'(pop_total - s_total), 64'd0);
    chk("empty_mvalid_cycles", 64'(mv_cycles - s_mv), 64'd0);
    chk("empty_update_cycles", 64'(upd_cycles - s_upd), 64'd0);

    // back-to-back 0,3,0,3 at one transaction per 3 cycles
    snap();
    bus.q_empty = 4'b0000; bus.m_ready = 1'b1;
    bus.q_data[0] = 32'h0000A000; bus.q_data[3] = 32'h0000A003;
    bus.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.selection = k[0] ? 2'd3 : 2'd0;
      exp_q.push_back(k[0] ? txn_t'{32'h0000A003, 2'd3} : txn_t'{32'h0000A000, 2'd0});
      cyc(3);
    end
    bus.valid = 1'b0;
    chk("b2b_handshakes_12cyc", 64'(hs_cnt - s_hs), 64'd4);
    drain();
    chk("b2b_update_falls", 64'(fall_cnt - s_fall), 64'd4);
    chk("b2b_pop_q0", 64'(pop_cnt[0] - s_pop[0]), 64'd2);
    chk("b2b_pop_q3", 64'(pop_cnt[3] - s_pop[3]), 64'd2);
    chk("b2b_served0", 64'(served_count[0]), 64'd2);
    chk("b2b_served3", 64'(served_count[3]), 64'd2);

    // reset asserted on the second SEND cycle
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    snap();
    bus.selection = 1; bus.m_ready = 1'b0;
    bus.valid = 1'b1; cyc(1); bus.valid = 1'b0;
    cyc(1);
    reset = 1'b1; cyc(1);
    chk("rstsend_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rstsend_update", 64'(bus.update), 64'd0);
    reset = 1'b0; bus.m_ready = 1'b1;
    cyc(4);
    chk("rstsend_no_handshake", 64'(hs_cnt - s_hs), 64'd0);
    chk("rstsend_pop_total", 64'(pop_total - s_total), 64'd1);
    chk("rstsend_mvalid_cycles", 64'(mv_cycles - s_mv), 64'd2);
    chk("rstsend_served", 64'(served_count), 64'd0);

    // saturation at 3, then clear coincident with a handshake
    snap();
    bus.selection = 0;
    for (int k = 0; k < 5; k++) exp_q.push_back('{32'h0000A000, 2'd0});
    bus.valid = 1'b1; cyc(15); bus.valid = 1'b0;
    drain();
    chk("sat_handshakes", 64'(hs_cnt - s_hs), 64'd5);
    e_cnt = '0; e_cnt[0] = 2'd3;
    chk("sat_served", 64'(served_count), 64'(e_cnt));
    exp_q.push_back('{32'h0000A000, 2'd0});
    bus.valid = 1'b1; cyc(1); bus.valid = 1'b0;
    clear_counts = 1'b1; cyc(1); clear_counts = 1'b0;
    chk("clear_over_inc", 64'(served_count), 64'd0);
    drain();
    chk("clear_hold", 64'(served_count), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
